xor_rmw_writer: RTL

XOR_RMW_WRITER -- requirements
Module: xor_rmw_writer

---
 rtl/xor_rmw_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/xor_rmw_writer.sv
// xor_rmw_writer: pipelined read-modify-write XOR accumulator over a URAM table
// with write forwarding for the 2-cycle read latency and a drain-then-clear FSM.
module xor_rmw_writer #(
   parameter int NUM_MUL     = 4,
   parameter int INDEX_WIDTH = 12,
   parameter int DATA_WIDTH  = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INDEX_WIDTH-1:0]        in_index,
   input  logic [NUM_MUL*DATA_WIDTH-1:0] in_xor,
   input  logic                          clear_start,
   output logic                          uram_rd_en,
   output logic [INDEX_WIDTH-1:0]        uram_rd_addr,
   input  logic [NUM_MUL*DATA_WIDTH-1:0] uram_rd_data,
   output logic                          uram_wr_en,
   output logic [INDEX_WIDTH-1:0]        uram_wr_addr,
   output logic [NUM_MUL*DATA_WIDTH-1:0] uram_wr_data,
   output logic [INDEX_WIDTH-1:0]        write_reg_0_index,
   output logic                          write_reg_0_valid,
   output logic [INDEX_WIDTH-1:0]        write_reg_1_index,
   output logic                          write_reg_1_valid,
   output logic                          clear_done,
   output logic                          busy,
   output logic [31:0]                   update_count
);
   localparam int W = NUM_MUL*DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   state_t                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] clr_q, clr_d;
   logic [31:0]            cnt_q, cnt_d;
   logic                   v1_q, v2_q, v3_q, hv1_q, hv2_q;
   logic [INDEX_WIDTH-1:0] i1_q, i2_q, i3_q, hi1_q, hi2_q;
   logic [W-1:0]           x1_q, x2_q, d3_q, d3_d, hd1_q, hd2_q, fwd;
   logic                   accept, clearing, any_v;

   assign accept   = in_valid && in_ready;
   assign clearing = state_q == CLEAR;
   assign any_v    = v1_q | v2_q | v3_q | hv1_q | hv2_q;

   // The three writes ahead of T2 are not yet visible in uram_rd_data; youngest wins.
   assign fwd  = (v3_q  && i3_q  == i2_q) ? d3_q  :
                 (hv1_q && hi1_q == i2_q) ? hd1_q :
                 (hv2_q && hi2_q == i2_q) ? hd2_q : uram_rd_data;
   assign d3_d = fwd ^ x2_q;
   assign cnt_d = v3_q ? cnt_q + 32'd1 : cnt_q;
   assign clr_d = clearing ? clr_q + 1'b1 : '0;

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      clear_done = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (clear_start) state_d = DRAIN;
         end
         DRAIN: if (!any_v) state_d = CLEAR;
         CLEAR: if (&clr_q) begin
            clear_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         clr_q   <= '0;
         cnt_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         hv1_q   <= 1'b0;
         hv2_q   <= 1'b0;
         i1_q    <= '0;
         i2_q    <= '0;
         i3_q    <= '0;
         hi1_q   <= '0;
         hi2_q   <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         d3_q    <= '0;
         hd1_q   <= '0;
         hd2_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         cnt_q   <= cnt_d;
         v1_q    <= accept;
         i1_q    <= in_index;
         x1_q    <= in_xor;
         v2_q    <= v1_q;
         i2_q    <= i1_q;
         x2_q    <= x1_q;
         v3_q    <= v2_q;
         i3_q    <= i2_q;
         d3_q    <= d3_d;
         hv1_q   <= v3_q;
         hi1_q   <= i3_q;
         hd1_q   <= d3_q;
         hv2_q   <= hv1_q;
         hi2_q   <= hi1_q;
         hd2_q   <= hd1_q;
      end
   end

   assign uram_rd_en        = accept;
   assign uram_rd_addr      = in_index;
   assign uram_wr_en        = v3_q | clearing;
   assign uram_wr_addr      = clearing ? clr_q : i3_q;
   assign uram_wr_data      = clearing ? '0 : d3_q;
   assign write_reg_0_index = i3_q;
   assign write_reg_0_valid = v3_q;
   assign write_reg_1_index = hi1_q;
   assign write_reg_1_valid = hv1_q;
   assign busy              = (state_q != IDLE) | any_v;
   assign update_count      = cnt_q;
endmodule
